// File: rtl/spi_slave_tx_64.sv
// SPI mode-0 slave transmitter: single-entry holding register, IRQ level,
// MSB-first shift-out on MISO with all SPI pins oversampled on i_Clk.
module spi_slave_tx_64 #(
    parameter int unsigned           WORD_BITS   = 64,
    parameter logic [WORD_BITS-1:0]  IDLE_WORD   = '0,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_TX_DV,
    input  logic [WORD_BITS-1:0] i_TX_64Bit,
    output logic                 o_TX_Ready,
    output logic                 o_TX_Done,
    output logic                 o_TX_Abort,
    output logic                 o_IRQ,
    input  logic                 i_SPI_Clk,
    input  logic                 i_SPI_CS_n,
    output logic                 o_SPI_MISO,
    output logic                 o_SPI_MISO_En
);

    localparam int unsigned CNT_W = $clog2(WORD_BITS) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
    logic                   sck_prev_q, cs_prev_q;

    logic [0:0]           state_q,    state_d;
    logic [WORD_BITS-1:0] hold_q,     hold_d;
    logic                 hv_q,       hv_d;
    logic                 active_q,   active_d;
    logic [WORD_BITS-1:0] shift_q,    shift_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 ready_q,    ready_d;
    logic                 done_q,     done_d;
    logic                 abort_q,    abort_d;
    logic                 irq_q,      irq_d;
    logic                 miso_q,     miso_d;
    logic                 miso_en_q,  miso_en_d;

    logic sck_s, cs_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    // Synchronizer shift: new pin value enters at bit 0, synced level leaves at the MSB
    always_comb begin
        sck_sync_d = (sck_sync_q << 1) | SYNC_STAGES'(i_SPI_Clk);
        cs_sync_d  = (cs_sync_q  << 1) | SYNC_STAGES'(i_SPI_CS_n);
        sck_s      = sck_sync_q[SYNC_STAGES-1];
        cs_s       = cs_sync_q[SYNC_STAGES-1];
        sck_rise   = sck_s & ~sck_prev_q;
        sck_fall   = ~sck_s & sck_prev_q;
        cs_rise    = cs_s & ~cs_prev_q;
        cs_fall    = ~cs_s & cs_prev_q;
    end

    // Synchronizer, edge-detect and datapath registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hv_q       <= 1'b0;
            active_q   <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            irq_q      <= 1'b0;
            miso_q     <= 1'b0;
            miso_en_q  <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            state_q    <= state_d;
            hold_q     <= hold_d;
            hv_q       <= hv_d;
            active_q   <= active_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            irq_q      <= irq_d;
            miso_q     <= miso_d;
            miso_en_q  <= miso_en_d;
        end
    end

    // Next-state: holding-register write, IDLE preload, SHIFT bit counting and shifting
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        hv_d     = hv_q;
        active_d = active_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;

        if (i_TX_DV && ready_q) begin
            hold_d = i_TX_64Bit;
            hv_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                shift_d = hv_q ? hold_q : IDLE_WORD;
                if (cs_fall) begin
                    active_d = hv_q;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    // CS_n rise takes priority over any SCK edge in the same cycle
                    if (active_q && (cnt_q != '0) && (cnt_q < CNT_W'(WORD_BITS))) begin
                        abort_d = 1'b1;
                    end
                    active_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    if (sck_rise && (cnt_q != CNT_W'(WORD_BITS))) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if ((cnt_q == CNT_W'(WORD_BITS - 1)) && active_q) begin
                            done_d   = 1'b1;
                            hv_d     = 1'b0;
                            active_d = 1'b0;
                        end
                    end
                    if (sck_fall) begin
                        shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready stays low through the Done cycle so a coincident write is refused
        ready_d   = ~hv_d & ~done_d;
        irq_d     = hv_d;
        miso_d    = shift_d[WORD_BITS-1];
        miso_en_d = (state_d == ST_SHIFT);
    end

    assign o_TX_Ready    = ready_q;
    assign o_TX_Done     = done_q;
    assign o_TX_Abort    = abort_q;
    assign o_IRQ         = irq_q;
    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_En = miso_en_q;

endmodule

// File: tb/tb_spi_slave_tx_64.sv
// Self-checking bench for spi_slave_tx_64: directed and randomized SPI reads
// compared against a pending-word reference model.
module tb_spi_slave_tx_64;

    localparam int WB = 64;

    logic          i_Clk      = 1'b0;
    logic          i_Rst_L    = 1'b0;
    logic          i_TX_DV    = 1'b0;
    logic [WB-1:0] i_TX_64Bit = '0;
    logic          i_SPI_Clk  = 1'b0;
    logic          i_SPI_CS_n = 1'b1;
    logic          o_TX_Ready, o_TX_Done, o_TX_Abort, o_IRQ;
    logic          o_SPI_MISO, o_SPI_MISO_En;

    spi_slave_tx_64 dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_TX_DV       (i_TX_DV),
        .i_TX_64Bit    (i_TX_64Bit),
        .o_TX_Ready    (o_TX_Ready),
        .o_TX_Done     (o_TX_Done),
        .o_TX_Abort    (o_TX_Abort),
        .o_IRQ         (o_IRQ),
        .i_SPI_Clk     (i_SPI_Clk),
        .i_SPI_CS_n    (i_SPI_CS_n),
        .o_SPI_MISO    (o_SPI_MISO),
        .o_SPI_MISO_En (o_SPI_MISO_En)
    );

    always #5 i_Clk = ~i_Clk;

    int checks      = 0;
    int errors      = 0;
    int done_total  = 0;
    int abort_total = 0;
    int done_at     = -1;
    int rise_cnt    = 0;

    // Reference model: is a word pending, and which one
    bit            m_pend = 1'b0;
    logic [WB-1:0] m_word = '0;

    // Pulse monitor, sampled on the falling clock edge
    always @(negedge i_Clk) begin
        if (o_TX_Done) begin
            done_total++;
            done_at = rise_cnt;
        end
        if (o_TX_Abort) abort_total++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    // Bits an SPI master sees: the pending word MSB first, then zeros; all zeros if idle
    function automatic logic [127:0] exp_bits(input bit pend, input logic [WB-1:0] w, input int n);
        logic [127:0] e;
        e = '0;
        for (int i = 0; i < n; i++) e = {e[126:0], (pend && i < WB) ? w[WB-1-i] : 1'b0};
        return e;
    endfunction

    task automatic write_word(input logic [WB-1:0] w);
        if (!m_pend) begin
            m_pend = 1'b1;
            m_word = w;
        end
        i_TX_DV    = 1'b1;
        i_TX_64Bit = w;
        tick(1);
        i_TX_DV    = 1'b0;
        chk("irq_after_write", 128'(o_IRQ), 128'(1));
        chk("ready_after_write", 128'(o_TX_Ready), 128'(0));
    endtask

    // Master read of n bits at 10 MHz; optional write strobe during bit dv_at
    task automatic xfer(input int n, input bit keep_cs, input int dv_at, input logic [WB-1:0] dv_w,
                        output logic [127:0] got, output logic en_seen);
        got      = '0;
        en_seen  = 1'b0;
        rise_cnt = 0;
        i_SPI_CS_n = 1'b0;
        tick(6);
        for (int i = 0; i < n; i++) begin
            got = {got[126:0], o_SPI_MISO};
            if (i == 0) en_seen = o_SPI_MISO_En;
            i_SPI_Clk = 1'b1;
            rise_cnt++;
            if (i == dv_at) begin
                i_TX_DV    = 1'b1;
                i_TX_64Bit = dv_w;
                tick(1);
                i_TX_DV    = 1'b0;
                tick(4);
            end else begin
                tick(5);
            end
            i_SPI_Clk = 1'b0;
            tick(5);
        end
        if (!keep_cs) begin
            i_SPI_CS_n = 1'b1;
            tick(8);
        end
    endtask

    // Full transaction checked against the model; dv_at>=0 issues a mid-transfer write
    task automatic txn(input string tag, input int n, input int dv_at, input logic [WB-1:0] dv_w);
        logic [127:0] got, exp;
        logic en;
        int d0, a0;
        bit exp_done, exp_abort, late_write;
        d0        = done_total;
        a0        = abort_total;
        exp       = exp_bits(m_pend, m_word, n);
        exp_done  = m_pend && (n >= WB);
        exp_abort = m_pend && (n >= 1) && (n < WB);
        late_write = (dv_at >= 0) && !m_pend;
        xfer(n, 1'b0, dv_at, dv_w, got, en);
        chk({tag, "_data"}, got, exp);
        chk({tag, "_done"}, 128'(done_total - d0), 128'(exp_done));
        chk({tag, "_abort"}, 128'(abort_total - a0), 128'(exp_abort));
        chk({tag, "_en"}, 128'(en), 128'(1));
        if (exp_done) begin
            chk({tag, "_done_at"}, 128'(done_at), 128'(WB));
            m_pend = 1'b0;
        end
        if (late_write) begin
            m_pend = 1'b1;
            m_word = dv_w;
        end
        chk({tag, "_ready"}, 128'(o_TX_Ready), 128'(!m_pend));
        chk({tag, "_irq"}, 128'(o_IRQ), 128'(m_pend));
    endtask

    initial begin
        logic [127:0] got;
        logic en;
        logic [WB-1:0] w;
        int d0, a0, n;

        // Reset state
        tick(3);
        chk("rst_ready", 128'(o_TX_Ready), 128'(1));
        chk("rst_done", 128'(o_TX_Done), 128'(0));
        chk("rst_abort", 128'(o_TX_Abort), 128'(0));
        chk("rst_irq", 128'(o_IRQ), 128'(0));
        chk("rst_miso", 128'(o_SPI_MISO), 128'(0));
        chk("rst_miso_en", 128'(o_SPI_MISO_En), 128'(0));
        i_Rst_L = 1'b1;
        tick(3);

        // 1: basic word
        write_word(64'hDEADBEEF_01234567);
        txn("t1", 64, -1, '0);

        // 2: no word pending
        txn("t2", 64, -1, '0);

        // 3: abort after 20 bits, then full resend
        write_word(64'hA5A5_A5A5_A5A5_A5A5);
        txn("t3a", 20, -1, '0);
        txn("t3b", 64, -1, '0);

        // 4: write while a word is mid-shift is ignored
        write_word({$urandom, $urandom});
        txn("t4a", 64, 20, {$urandom, $urandom});
        write_word(64'h1);
        txn("t4b", 64, -1, '0);

        // Write during an idle-pattern transfer lands in holding for the next one
        txn("t4c", 64, 10, {$urandom, $urandom});
        txn("t4d", 64, -1, '0);

        // 5: reset in the middle of a transfer
        write_word({$urandom, $urandom});
        d0 = done_total;
        a0 = abort_total;
        xfer(30, 1'b1, -1, '0, got, en);
        i_Rst_L = 1'b0;
        #1;
        chk("t5_miso", 128'(o_SPI_MISO), 128'(0));
        chk("t5_irq", 128'(o_IRQ), 128'(0));
        chk("t5_ready", 128'(o_TX_Ready), 128'(1));
        chk("t5_miso_en", 128'(o_SPI_MISO_En), 128'(0));
        m_pend = 1'b0;
        tick(1);
        i_SPI_CS_n = 1'b1;
        tick(3);
        i_Rst_L = 1'b1;
        tick(4);
        chk("t5_no_done", 128'(done_total - d0), 128'(0));
        chk("t5_no_abort", 128'(abort_total - a0), 128'(0));
        txn("t5b", 64, -1, '0);

        // 6: overlong transfer, zeros past the word and one Done at rise 64
        write_word({$urandom, $urandom});
        txn("t6", 70, -1, '0);

        // Randomized mix of writes (some while pending) and transfer lengths
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 2) != 0) write_word({$urandom, $urandom});
            case ($urandom_range(0, 3))
                0:       n = 63;
                1:       n = 64;
                default: n = int'($urandom_range(1, 70));
            endcase
            txn("rnd", n, -1, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_tx_64.md
Name: spi_slave_tx_64

Overview:
Transmit half of the MCU↔FPGA SPI link. It carries FPGA→MCU traffic such as status, frame-done and readback words. The controller deposits one 64-bit word into a single-entry holding register, and the block raises an interrupt level so the MCU starts a read transaction. The word is then shifted out MSB-first on MISO in SPI mode 0 (CPOL=0, CPHA=0), with all SPI inputs oversampled on the 100 MHz system clock.

Parameters:
WORD_BITS, 64, bits per transaction; the counter width is $clog2(WORD_BITS)+1.
IDLE_WORD, 64'h0, pattern shifted out when CS_n falls with no word pending.
SYNC_STAGES, 2, flip-flop stages on SCK, CS_n and MOSI-independent inputs.

Ports:
i_Clk  in  1  system clock, 100 MHz
i_Rst_L  in  1  asynchronous, active-low reset
i_TX_DV  in  1  single-cycle write strobe; accepted only when o_TX_Ready=1
i_TX_64Bit  in  WORD_BITS  word to transmit; sampled when i_TX_DV=1
o_TX_Ready  out  1  holding register empty
o_TX_Done  out  1  one-cycle pulse: pending word fully clocked out (all WORD_BITS bits)
o_TX_Abort  out  1  one-cycle pulse: CS_n rose after 1..WORD_BITS-1 bits of a pending word
o_IRQ  out  1  level, high while a word is pending; routed to the MCU interrupt pin
i_SPI_Clk  in  1  SPI SCK, asynchronous to i_Clk
i_SPI_CS_n  in  1  SPI chip select, active-low, asynchronous
o_SPI_MISO  out  1  serial data out
o_SPI_MISO_En  out  1  high while synchronized CS_n is low; top-level tri-state enable

Behaviour:
- Reset (asynchronous, active-low). All of the following are cleared:
  - o_TX_Ready=1, o_TX_Done=0, o_TX_Abort=0, o_IRQ=0, o_SPI_MISO=0, o_SPI_MISO_En=0.
  - holding_valid=0, shift register=0, bit counter=0, FSM=IDLE.
  - Synchronizer contents are reset to idle levels: SCK=0, CS_n=1.
  - A reset during a transfer takes effect immediately. The pending word is discarded, and no Done or Abort pulse is generated.
- Synchronization:
  - SCK and CS_n each pass through SYNC_STAGES flip-flops, plus one edge-detect register.
  - Edges are therefore seen SYNC_STAGES+1 i_Clk cycles after the pin changes.
  - Required SCK frequency ≤ i_Clk/8, i.e. at most 12.5 MHz.
  - Required CS_n-fall to first SCK rise ≥ 4 i_Clk cycles.
- Holding register:
  - Write occurs when i_TX_DV=1 and holding_valid=0. On the next cycle holding=i_TX_64Bit, holding_valid=1, o_TX_Ready=0.
  - i_TX_DV while o_TX_Ready=0 is ignored and does not overwrite the held word.
  - o_IRQ = holding_valid, registered.
- o_SPI_MISO is always shift_reg[WORD_BITS-1], registered. No combinational path from pins to MISO.
- FSM state IDLE (synced CS_n=1):
  - Every cycle, shift_reg = holding_valid ? holding : IDLE_WORD, so the MSB is already on MISO before CS_n falls.
  - Bit counter is held at 0.
  - On synced CS_n fall: latch active_valid=holding_valid, go to SHIFT.
- FSM state SHIFT (synced CS_n=0):
  - Synced SCK rise: counter += 1, saturating at WORD_BITS.
    - When the counter reaches WORD_BITS with active_valid=1: pulse o_TX_Done, clear holding_valid (o_TX_Ready=1, o_IRQ=0 on the next cycle), clear active_valid.
  - Synced SCK fall: shift_reg <<= 1 with a 0 shifted in. Bits beyond WORD_BITS are 0.
  - A word written during SHIFT lands in holding only. It does not affect the current transfer and is loaded on return to IDLE.
  - Synced CS_n rise: go to IDLE.
    - If active_valid=1 and 1 ≤ counter ≤ WORD_BITS-1: pulse o_TX_Abort. holding_valid stays 1, so the same word is resent on the next transaction.
    - If counter=0: no pulse, word retained.
- Simultaneous events:
  - SCK edge and CS_n rise in the same cycle: CS_n rise wins; the edge is ignored.
  - Done and i_TX_DV in the same cycle: DV is ignored, because o_TX_Ready is still 0 that cycle.
- o_TX_Done and o_TX_Abort are mutually exclusive per transaction.

Test Plan:
1. Write 64'hDEADBEEF_01234567, then assert CS_n and run 64 SCK cycles at 10 MHz.
   - o_IRQ rises 1 cycle after the write.
   - MISO sampled on SCK rises gives DEADBEEF01234567, MSB first.
   - o_TX_Done pulses once; o_TX_Ready=1 and o_IRQ=0 afterwards.
2. Run a transaction with no word pending.
   - 64 bits of IDLE_WORD (all 0).
   - No Done, no Abort; o_TX_Ready stays 1.
3. Write 64'hA5A5_A5A5_A5A5_A5A5, clock 20 bits, then release CS_n.
   - o_TX_Abort pulses; o_IRQ stays 1.
   - A second full transaction returns A5A5A5A5A5A5A5A5 and pulses Done.
4. While word 1 is mid-shift, issue i_TX_DV with word 2.
   - Write is ignored (Ready=0); word 1 completes.
   - A subsequent write of 64'h1 succeeds; the next transaction returns 0000000000000001.
5. Write a word, clock 30 bits, then pulse i_Rst_L low.
   - Immediately: MISO=0, o_IRQ=0, o_TX_Ready=1, no Done or Abort.
   - Next transaction shifts IDLE_WORD.
6. Run 70 SCK cycles with a word pending.
   - Bits 65–70 read 0.
   - Exactly one Done pulse, asserted at the 64th rise.
